// File: rtl/store_buffer.sv
// In-order store buffer between EX/MEM and the data-memory write port.
// Queues accepted stores, drains them over valid/ready and forwards full-word hits to loads.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     mem_we_i,
  input  logic [ADDR_W-1:0]        st_addr_i,
  input  logic [DATA_W-1:0]        st_data_i,
  input  logic [3:0]               st_strb_i,
  output logic                     st_ready_o,
  input  logic                     fence_i,
  input  logic                     ld_req_i,
  input  logic [ADDR_W-1:0]        ld_addr_i,
  output logic                     ld_hit_o,
  output logic [DATA_W-1:0]        ld_data_o,
  output logic                     ld_stall_o,
  output logic                     dmem_we_o,
  output logic [ADDR_W-1:0]        dmem_addr_o,
  output logic [DATA_W-1:0]        dmem_wdata_o,
  output logic [3:0]               dmem_strb_o,
  input  logic                     dmem_ready_i,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [ADDR_W-1:0] r_addr_mem [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [3:0]        r_strb_mem [DEPTH];

  logic              w_nonempty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_unused_ld_lsb;

  logic [DEPTH-1:0]  w_match;
  logic [DEPTH-1:0]  w_whole;
  logic [DATA_W-1:0] w_fwd_data [DEPTH];

  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == CNT_W'(DEPTH));

  // Readiness depends only on registered state, so a pop never makes room for a same-cycle push.
  assign st_ready_o = ~w_full & ~(fence_i & w_nonempty);
  assign w_push     = mem_we_i & st_ready_o;
  assign w_pop      = dmem_we_o & dmem_ready_i;

  assign dmem_we_o    = w_nonempty;
  assign dmem_addr_o  = w_nonempty ? r_addr_mem[r_head] : '0;
  assign dmem_wdata_o = w_nonempty ? r_data_mem[r_head] : '0;
  assign dmem_strb_o  = w_nonempty ? r_strb_mem[r_head] : 4'h0;
  assign empty_o      = ~w_nonempty;
  assign count_o      = r_count;

  assign w_unused_ld_lsb = ^ld_addr_i[1:0];

  // Slot gi holds the entry of age gi (0 = oldest); zero-strobe entries never forward.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_age
      logic [PTR_W-1:0] w_idx;
      assign w_idx          = r_head + PTR_W'(gi);
      assign w_match[gi]    = ld_req_i && (CNT_W'(gi) < r_count) &&
                              (r_addr_mem[w_idx][ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2]) &&
                              (r_strb_mem[w_idx] != 4'h0);
      assign w_whole[gi]    = (r_strb_mem[w_idx] == 4'hF);
      assign w_fwd_data[gi] = r_data_mem[w_idx];
    end
  endgenerate

  // Walk oldest to youngest so the youngest match has the final say.
  always_comb begin
    ld_hit_o   = 1'b0;
    ld_stall_o = 1'b0;
    ld_data_o  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_match[k]) begin
        if (w_whole[k]) begin
          ld_hit_o   = 1'b1;
          ld_stall_o = 1'b0;
          ld_data_o  = w_fwd_data[k];
        end else begin
          ld_hit_o   = 1'b0;
          ld_stall_o = 1'b1;
          ld_data_o  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_addr_mem[r_tail] <= st_addr_i;
      r_data_mem[r_tail] <= st_data_i;
      r_strb_mem[r_tail] <= st_strb_i;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed vectors, handshake/fence/reset sequences
// and a randomized run against a queue-based reference model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        mem_we_i;
  logic [31:0] st_addr_i;
  logic [31:0] st_data_i;
  logic [3:0]  st_strb_i;
  logic        st_ready_o;
  logic        fence_i;
  logic        ld_req_i;
  logic [31:0] ld_addr_i;
  logic        ld_hit_o;
  logic [31:0] ld_data_o;
  logic        ld_stall_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_strb_o;
  logic        dmem_ready_i;
  logic        empty_o;
  logic [2:0]  count_o;

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .mem_we_i(mem_we_i),
    .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_strb_i(st_strb_i),
    .st_ready_o(st_ready_o), .fence_i(fence_i), .ld_req_i(ld_req_i),
    .ld_addr_i(ld_addr_i), .ld_hit_o(ld_hit_o), .ld_data_o(ld_data_o),
    .ld_stall_o(ld_stall_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_strb_o(dmem_strb_o),
    .dmem_ready_i(dmem_ready_i), .empty_o(empty_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic fe, input logic lr,
                       input logic [31:0] la, input logic rdy);
    mem_we_i = we; st_addr_i = a; st_data_i = d; st_strb_i = s;
    fence_i = fe; ld_req_i = lr; ld_addr_i = la; dmem_ready_i = rdy;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] ld_addr;
    logic        rdy;
    logic        e_ready;
    logic        e_we;
    logic [2:0]  e_cnt;
    logic        e_hit;
    logic        e_stall;
    logic [31:0] e_ldata;
    logic [31:0] e_daddr;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } ent_t;

  vec_t vec [10];
  ent_t q [$];
  logic [31:0] drain_exp [4];

  initial begin
    logic        e_ready, e_hit, e_stall, e_we, r_we, r_fe, r_lr, r_rdy, pushed;
    logic [31:0] e_ld, r_a, r_d, r_la;
    logic [3:0]  r_s;
    ent_t        hd;

    vec[0] = '{1'b0, 32'h0,   32'h0,        4'h0, 32'h100, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0,        32'h0};
    vec[1] = '{1'b1, 32'h200, 32'h11111111, 4'hF, 32'h200, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0,        32'h0};
    vec[2] = '{1'b1, 32'h200, 32'h22222222, 4'hF, 32'h202, 1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0, 32'h11111111, 32'h200};
    vec[3] = '{1'b1, 32'h300, 32'hAABBCCDD, 4'h3, 32'h202, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 32'h22222222, 32'h200};
    vec[4] = '{1'b1, 32'h304, 32'h5,        4'h0, 32'h300, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 1'b1, 32'h0,        32'h200};
    vec[5] = '{1'b0, 32'h0,   32'h0,        4'h0, 32'h304, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 32'h0,        32'h200};
    vec[6] = '{1'b1, 32'h400, 32'h77,       4'hF, 32'h304, 1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 32'h0,        32'h200};
    vec[7] = '{1'b1, 32'h400, 32'h77,       4'hF, 32'h200, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 32'h22222222, 32'h200};
    vec[8] = '{1'b0, 32'h0,   32'h0,        4'h0, 32'h400, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 32'h77,       32'h200};
    vec[9] = '{1'b0, 32'h0,   32'h0,        4'h0, 32'h300, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 32'h0,        32'h200};
    drain_exp = '{32'h200, 32'h300, 32'h304, 32'h400};

    rst_n_i = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 1'b0);
    #3;
    chk("rst_dmem_we", dmem_we_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_count", count_o, 0);
    chk("rst_ready", st_ready_o, 1);
    chk("rst_hit", ld_hit_o, 0);
    chk("rst_stall", ld_stall_o, 0);
    chk("rst_ldata", ld_data_o, 0);
    chk("rst_daddr", dmem_addr_o, 0);
    chk("rst_dwdata", dmem_wdata_o, 0);
    chk("rst_dstrb", dmem_strb_o, 0);
    cycle(); cycle();
    rst_n_i = 1'b1;
    cycle();

    // Backpressured head must hold steady until ready.
    drive(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle();
    mem_we_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("hs_we", dmem_we_o, 1);
      chk("hs_addr", dmem_addr_o, 32'h100);
      chk("hs_data", dmem_wdata_o, 32'hDEADBEEF);
      chk("hs_strb", dmem_strb_o, 4'hF);
      chk("hs_count", count_o, 1);
      cycle();
    end
    dmem_ready_i = 1'b1;
    #3;
    chk("hs_we_pop", dmem_we_o, 1);
    cycle();
    dmem_ready_i = 1'b0;
    #3;
    chk("hs_empty", empty_o, 1);
    chk("hs_count0", count_o, 0);
    cycle();

    foreach (vec[i]) begin
      drive(vec[i].we, vec[i].addr, vec[i].data, vec[i].strb, 1'b0, 1'b1, vec[i].ld_addr, vec[i].rdy);
      #3;
      chk($sformatf("v%0d_ready", i), st_ready_o, vec[i].e_ready);
      chk($sformatf("v%0d_we", i), dmem_we_o, vec[i].e_we);
      chk($sformatf("v%0d_count", i), count_o, vec[i].e_cnt);
      chk($sformatf("v%0d_hit", i), ld_hit_o, vec[i].e_hit);
      chk($sformatf("v%0d_stall", i), ld_stall_o, vec[i].e_stall);
      chk($sformatf("v%0d_ldata", i), ld_data_o, vec[i].e_ldata);
      chk($sformatf("v%0d_daddr", i), dmem_addr_o, vec[i].e_daddr);
      cycle();
    end

    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #3;
      chk($sformatf("drain%0d_we", i), dmem_we_o, 1);
      chk($sformatf("drain%0d_addr", i), dmem_addr_o, drain_exp[i]);
      cycle();
    end
    #3;
    chk("drain_empty", empty_o, 1);
    dmem_ready_i = 1'b0;
    cycle();

    // Fence holds off new stores until the queue empties.
    drive(1'b1, 32'h500, 32'h5, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle();
    st_addr_i = 32'h504;
    cycle();
    drive(1'b1, 32'h600, 32'h6, 4'hF, 1'b1, 1'b0, 32'h0, 1'b1);
    begin
      int guard;
      guard = 0;
      #3;
      while (count_o != 0 && guard < 10) begin
        chk("fence_ready_low", st_ready_o, 0);
        cycle();
        #3;
        guard++;
      end
      chk("fence_drain_bound", guard, 2);
      chk("fence_empty", empty_o, 1);
      chk("fence_ready_back", st_ready_o, 1);
    end
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    cycle();

    // Randomized run against a queue model.
    q.delete();
    for (int c = 0; c < 600; c++) begin
      r_we  = ($urandom_range(0, 9) < 6);
      r_a   = 32'h1000 + ($urandom_range(0, 5) << 2) + $urandom_range(0, 3);
      r_d   = $urandom;
      r_s   = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
      r_fe  = ($urandom_range(0, 9) == 0);
      r_lr  = ($urandom_range(0, 3) != 0);
      r_la  = 32'h1000 + ($urandom_range(0, 5) << 2) + $urandom_range(0, 3);
      r_rdy = ($urandom_range(0, 1) == 1);
      drive(r_we, r_a, r_d, r_s, r_fe, r_lr, r_la, r_rdy);

      e_ready = (q.size() != DEPTH) && !(r_fe && q.size() != 0);
      e_we    = (q.size() != 0);
      e_hit = 1'b0; e_stall = 1'b0; e_ld = 32'h0;
      if (r_lr) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].strb != 4'h0 && q[i].addr[31:2] == r_la[31:2]) begin
            if (q[i].strb == 4'hF) begin
              e_hit = 1'b1; e_ld = q[i].data;
            end else begin
              e_stall = 1'b1;
            end
            break;
          end
        end
      end
      hd = e_we ? q[0] : '0;
      #3;
      chk("rnd_ready", st_ready_o, e_ready);
      chk("rnd_we", dmem_we_o, e_we);
      chk("rnd_count", count_o, q.size());
      chk("rnd_empty", empty_o, q.size() == 0);
      chk("rnd_hit", ld_hit_o, e_hit);
      chk("rnd_stall", ld_stall_o, e_stall);
      chk("rnd_ldata", ld_data_o, e_ld);
      chk("rnd_daddr", dmem_addr_o, hd.addr);
      chk("rnd_dwdata", dmem_wdata_o, hd.data);
      chk("rnd_dstrb", dmem_strb_o, hd.strb);
      pushed = r_we && e_ready;
      if (e_we && r_rdy) void'(q.pop_front());
      if (pushed) q.push_back('{r_a, r_d, r_s});
      cycle();
    end

    // Reset mid-transfer clears the queue without waiting for an edge.
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    while (count_o != 0) cycle();
    dmem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h700 + 32'(i * 4), 32'(i), 4'hF, 1'b0, 1'b0, 32'h0, 1'b0);
      cycle();
    end
    mem_we_i = 1'b0;
    dmem_ready_i = 1'b1;
    #1;
    chk("pre_rst_count", count_o, 3);
    rst_n_i = 1'b0;
    #1;
    chk("async_rst_we", dmem_we_o, 0);
    chk("async_rst_count", count_o, 0);
    chk("async_rst_empty", empty_o, 1);
    cycle();
    rst_n_i = 1'b1;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
